gray_decoder_monitor: RTL and testbench
=======================================

GRAY_DECODER_MONITOR -- requirements
Module: gray_decoder_monitor

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, Gray code width in bits (legal range 2..16).
REQ-002 Port clk SHALL be: clk  input  1  single clock, rising-edge active.
REQ-003 Port set SHALL be: set  input  1  asynchronous, active-low reset.
REQ-004 Port gray_in SHALL be: gray_in  input  WIDTH  Gray-coded count from the counter being monitored.
REQ-005 Port sample_en SHALL be: sample_en  input  1  accept gray_in on this clk edge.
REQ-006 Port bin_out SHALL be: bin_out  output  WIDTH  registered binary value decoded from the last accepted sample.
REQ-007 Port valid SHALL be: valid  output  1  one-cycle pulse, bin_out updated by an accepted sample.
REQ-008 Port dir_up SHALL be: dir_up  output  1  direction of the last legal single-bit step (1 = up).
REQ-009 Port step_err SHALL be: step_err  output  1  one-cycle pulse, illegal multi-bit transition.
REQ-010 Port wrap SHALL be: wrap  output  1  one-cycle pulse, legal step across the 2^WIDTH-1 / 0 boundary.
REQ-011 Port err_cnt SHALL be: err_cnt  output  8  saturating count of step_err events.
REQ-012 Port fault SHALL be: fault  output  1  high while the FSM is in FAULT.

Function
REQ-013 Decode SHALL be: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i].
REQ-014 Latency SHALL be 1 clk from the accepting edge to bin_out/valid/step_err/wrap/dir_up, with no synchronizer compiled in.
REQ-015 FSM states SHALL be IDLE (no sample yet), TRACK, and FAULT.
REQ-016 IDLE: the first accepted sample SHALL load bin_out and the previous-sample register, pulse valid, perform no step check, and go to TRACK.
REQ-017 TRACK/FAULT: each accepted sample SHALL be compared with the previous sampled Gray value by Hamming distance d.
REQ-018 d = 0: the FSM SHALL pulse valid, keep dir_up unchanged, and raise no error (stall).
REQ-019 d = 1: the FSM SHALL pulse valid, set dir_up = 1 if new_bin == (prev_bin + 1) mod 2^WIDTH and 0 otherwise, and move FAULT to TRACK.
REQ-020 d = 1 with prev_bin = 2^WIDTH-1 and new_bin = 0, or with prev_bin = 0 and new_bin = 2^WIDTH-1: the FSM SHALL also pulse wrap.
REQ-021 d > 1: the FSM SHALL pulse valid and step_err, increment err_cnt saturating at 255, load bin_out with the new value, keep dir_up unchanged, and go to (or stay in) FAULT.
REQ-022 sample_en = 0: all registers SHALL hold, and valid, step_err and wrap SHALL be 0.
REQ-023 The previous-sample register SHALL be updated on every accepted sample, including erroneous ones.
REQ-024 Pulse outputs SHALL never stay high for two consecutive cycles unless two samples are accepted back-to-back.

Reset
REQ-025 When set is low, the block SHALL asynchronously force: bin_out=0, valid=0, dir_up=1, step_err=0, wrap=0, err_cnt=0, fault=0, FSM=IDLE, previous-sample register=0, synchronizer flops=0.
REQ-026 Reset deassertion SHALL be sampled on clk, and the first accepted sample after release SHALL follow the IDLE rule.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight synchronized sample.

Configuration
REQ-028 Macro GRAY_MON_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer on gray_in and sample_en, giving a latency of 3 clk from the input change to the outputs.
REQ-029 Without GRAY_MON_SYNC_EN, gray_in and sample_en SHALL be used directly, giving a latency of 1 clk.

Verification
REQ-030 Scenario: reset, then gray_in 0000 -> 0001 -> 0011 -> 0010 with sample_en each cycle -> bin_out 0,1,2,3; dir_up=1; valid pulses x4; step_err never.
REQ-031 Scenario: up-wrap, gray 1000 (15) -> 0000 -> bin_out 15 then 0; wrap pulses once; dir_up=1.
REQ-032 Scenario: down-step, gray 0101 (6) -> 0111 (5) -> bin_out 5; dir_up=0; down-wrap 0000 -> 1000 gives wrap=1, bin_out=15.
REQ-033 Scenario: illegal jump, gray 0010 (3) -> 0101 (6) -> step_err pulse; err_cnt=1; fault=1; next legal 0101 -> 0100 (7) gives fault=0.
REQ-034 Scenario: 300 consecutive illegal jumps -> err_cnt saturates at 255 with no rollover.
REQ-035 Scenario: set asserted low mid-stream with bin_out=9 -> all outputs at reset values in the same cycle; the next sample follows the IDLE rule (no step_err).

Source files
------------

// File: rtl/gray_decoder_monitor.sv
// gray_decoder_monitor
//
// Watches the Gray-coded output of a counter, decodes each accepted sample
// to binary and classifies the step from the previous sample:
//   - stall (no bit changed), legal single-bit step (up or down, including
//     the all-ones <-> zero wrap), or illegal multi-bit jump.
// Illegal jumps are counted (saturating at 255) and park the FSM in FAULT
// until the next legal single-bit step.
//
// Optional build macro: GRAY_MON_SYNC_EN
//   When defined, gray_in and sample_en pass through a 2-flop synchronizer
//   before use (3 clk from input change to outputs). When undefined, they
//   are used directly (1 clk from the accepting edge to outputs).
//
// Ports:
//   clk        in   1      rising-edge clock
//   set        in   1      asynchronous active-low reset
//   gray_in    in   WIDTH  Gray-coded count being monitored
//   sample_en  in   1      accept gray_in on this edge
//   bin_out    out  WIDTH  binary value of the last accepted sample
//   valid      out  1      pulse: bin_out updated
//   dir_up     out  1      direction of last legal step (1 = up)
//   step_err   out  1      pulse: illegal multi-bit transition
//   wrap       out  1      pulse: legal step across all-ones / zero
//   err_cnt    out  8      saturating count of step_err events
//   fault      out  1      high while the FSM is in FAULT
module gray_decoder_monitor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             set,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             dir_up,
  output logic             step_err,
  output logic             wrap,
  output logic [7:0]       err_cnt,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

  // Sample stream actually seen by the monitor (raw or synchronized).
  logic [WIDTH-1:0] s_gray;
  logic             s_en;

`ifdef GRAY_MON_SYNC_EN
  logic [WIDTH-1:0] sync1_gray_reg, sync2_gray_reg;
  logic             sync1_en_reg,   sync2_en_reg;

  // Clearing these on reset drops any sample still in flight.
  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      sync1_gray_reg <= '0;
      sync2_gray_reg <= '0;
      sync1_en_reg   <= 1'b0;
      sync2_en_reg   <= 1'b0;
    end else begin
      sync1_gray_reg <= gray_in;
      sync2_gray_reg <= sync1_gray_reg;
      sync1_en_reg   <= sample_en;
      sync2_en_reg   <= sync1_en_reg;
    end
  end

  assign s_gray = sync2_gray_reg;
  assign s_en   = sync2_en_reg;
`else
  assign s_gray = gray_in;
  assign s_en   = sample_en;
`endif

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  logic [WIDTH-1:0] new_bin;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign new_bin[gi] = ^s_gray[WIDTH-1:gi];
    end
  endgenerate

  state_t           state_reg,     state_next;
  logic [WIDTH-1:0] bin_out_reg,   bin_out_next;
  logic [WIDTH-1:0] prev_gray_reg, prev_gray_next;
  logic             dir_up_reg,    dir_up_next;
  logic             valid_reg,     valid_next;
  logic             step_err_reg,  step_err_next;
  logic             wrap_reg,      wrap_next;
  logic [7:0]       err_cnt_reg,   err_cnt_next;

  // Hamming distance classification: exactly one bit set <=> single step.
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] diff_m1;
  logic             single_step;
  logic [WIDTH-1:0] bin_inc;

  assign diff        = prev_gray_reg ^ s_gray;
  assign diff_m1     = diff - {{(WIDTH-1){1'b0}}, 1'b1};
  assign single_step = (diff != '0) && ((diff & diff_m1) == '0);
  // bin_out_reg always equals the decode of prev_gray_reg once out of IDLE.
  assign bin_inc     = bin_out_reg + {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      state_reg     <= IDLE;
      bin_out_reg   <= '0;
      prev_gray_reg <= '0;
      dir_up_reg    <= 1'b1;
      valid_reg     <= 1'b0;
      step_err_reg  <= 1'b0;
      wrap_reg      <= 1'b0;
      err_cnt_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      bin_out_reg   <= bin_out_next;
      prev_gray_reg <= prev_gray_next;
      dir_up_reg    <= dir_up_next;
      valid_reg     <= valid_next;
      step_err_reg  <= step_err_next;
      wrap_reg      <= wrap_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bin_out_next   = bin_out_reg;
    prev_gray_next = prev_gray_reg;
    dir_up_next    = dir_up_reg;
    err_cnt_next   = err_cnt_reg;
    valid_next     = 1'b0;
    step_err_next  = 1'b0;
    wrap_next      = 1'b0;

    if (s_en) begin
      // Every accepted sample, legal or not, becomes the new reference.
      valid_next     = 1'b1;
      prev_gray_next = s_gray;
      bin_out_next   = new_bin;

      if (state_reg == IDLE) begin
        state_next = TRACK;
      end else if (single_step) begin
        dir_up_next = (new_bin == bin_inc);
        wrap_next   = ((bin_out_reg == BIN_MAX) && (new_bin == '0)) ||
                      ((bin_out_reg == '0) && (new_bin == BIN_MAX));
        state_next  = TRACK;
      end else if (diff != '0) begin
        step_err_next = 1'b1;
        if (err_cnt_reg != 8'hFF) begin
          err_cnt_next = err_cnt_reg + 8'd1;
        end
        state_next = FAULT;
      end
      // diff == 0 is a stall: only valid pulses, state unchanged.
    end
  end

  assign bin_out  = bin_out_reg;
  assign valid    = valid_reg;
  assign dir_up   = dir_up_reg;
  assign step_err = step_err_reg;
  assign wrap     = wrap_reg;
  assign err_cnt  = err_cnt_reg;
  assign fault    = (state_reg == FAULT);

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Directed testbench for gray_decoder_monitor (WIDTH = 4, default build).
module tb_gray_decoder_monitor;

  logic       clk;
  logic       set;
  logic [3:0] gray_in;
  logic       sample_en;
  logic [3:0] bin_out;
  logic       valid;
  logic       dir_up;
  logic       step_err;
  logic       wrap;
  logic [7:0] err_cnt;
  logic       fault;

  int total = 0;
  int bad   = 0;

  // Gray code of binary index 0..15, written out by hand.
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_decoder_monitor #(.WIDTH(4)) dut (
    .clk       (clk),
    .set       (set),
    .gray_in   (gray_in),
    .sample_en (sample_en),
    .bin_out   (bin_out),
    .valid     (valid),
    .dir_up    (dir_up),
    .step_err  (step_err),
    .wrap      (wrap),
    .err_cnt   (err_cnt),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then observe 1 time unit after the edge.
  task automatic apply(input logic [3:0] g, input logic en);
    gray_in   = g;
    sample_en = en;
    @(posedge clk);
    #1;
    $display("t=%0t gray=%b en=%b -> bin=%0d valid=%b dir_up=%b err=%b wrap=%b cnt=%0d fault=%b",
             $time, g, en, bin_out, valid, dir_up, step_err, wrap, err_cnt, fault);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_bin"},   32'(bin_out),  32'd0);
    chk({tag, "_valid"}, 32'(valid),    32'd0);
    chk({tag, "_dir"},   32'(dir_up),   32'd1);
    chk({tag, "_err"},   32'(step_err), 32'd0);
    chk({tag, "_wrap"},  32'(wrap),     32'd0);
    chk({tag, "_cnt"},   32'(err_cnt),  32'd0);
    chk({tag, "_fault"}, 32'(fault),    32'd0);
  endtask

  initial begin
    set       = 1'b0;
    gray_in   = 4'b0000;
    sample_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    #2 set = 1'b1;

    // Count up 0..3, first sample follows the IDLE rule.
    for (int i = 0; i < 4; i++) begin
      apply(gray_tab[i], 1'b1);
      chk($sformatf("up%0d_bin", i), 32'(bin_out), 32'(i));
      chk($sformatf("up%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("up%0d_err", i), 32'(step_err), 32'd0);
      chk($sformatf("up%0d_dir", i), 32'(dir_up), 32'd1);
    end

    // sample_en low: everything holds, pulses low.
    apply(4'b0110, 1'b0);
    chk("hold_bin", 32'(bin_out), 32'd3);
    chk("hold_valid", 32'(valid), 32'd0);

    // Continue up to 15, no wrap on the way.
    for (int i = 4; i < 16; i++) begin
      apply(gray_tab[i], 1'b1);
      chk($sformatf("up%0d_bin", i), 32'(bin_out), 32'(i));
      chk($sformatf("up%0d_wrap", i), 32'(wrap), 32'd0);
    end
    chk("up15_dir", 32'(dir_up), 32'd1);

    // Up-wrap 15 -> 0.
    apply(4'b0000, 1'b1);
    chk("upwrap_bin", 32'(bin_out), 32'd0);
    chk("upwrap_wrap", 32'(wrap), 32'd1);
    chk("upwrap_dir", 32'(dir_up), 32'd1);

    // Stall: valid only, wrap pulse must not persist.
    apply(4'b0000, 1'b1);
    chk("stall_valid", 32'(valid), 32'd1);
    chk("stall_wrap", 32'(wrap), 32'd0);
    chk("stall_err", 32'(step_err), 32'd0);

    // Down-wrap 0 -> 15.
    apply(4'b1000, 1'b1);
    chk("dnwrap_bin", 32'(bin_out), 32'd15);
    chk("dnwrap_wrap", 32'(wrap), 32'd1);
    chk("dnwrap_dir", 32'(dir_up), 32'd0);

    // Down 15 -> 14.
    apply(4'b1001, 1'b1);
    chk("dn14_bin", 32'(bin_out), 32'd14);
    chk("dn14_dir", 32'(dir_up), 32'd0);
    chk("dn14_wrap", 32'(wrap), 32'd0);

    // Illegal 14 -> 3, then illegal 3 -> 6 (dir_up kept at 0).
    apply(4'b0010, 1'b1);
    chk("ill1_err", 32'(step_err), 32'd1);
    chk("ill1_bin", 32'(bin_out), 32'd3);
    chk("ill1_cnt", 32'(err_cnt), 32'd1);
    chk("ill1_fault", 32'(fault), 32'd1);
    apply(4'b0101, 1'b1);
    chk("ill2_err", 32'(step_err), 32'd1);
    chk("ill2_bin", 32'(bin_out), 32'd6);
    chk("ill2_cnt", 32'(err_cnt), 32'd2);
    chk("ill2_dir", 32'(dir_up), 32'd0);
    chk("ill2_valid", 32'(valid), 32'd1);

    // Legal 6 -> 7 clears FAULT.
    apply(4'b0100, 1'b1);
    chk("rec_fault", 32'(fault), 32'd0);
    chk("rec_err", 32'(step_err), 32'd0);
    chk("rec_bin", 32'(bin_out), 32'd7);
    chk("rec_dir", 32'(dir_up), 32'd1);
    chk("rec_cnt", 32'(err_cnt), 32'd2);

    // Down 7 -> 6 -> 5.
    apply(4'b0101, 1'b1);
    chk("dn6_dir", 32'(dir_up), 32'd0);
    apply(4'b0111, 1'b1);
    chk("dn5_bin", 32'(bin_out), 32'd5);
    chk("dn5_dir", 32'(dir_up), 32'd0);

    // 300 back-to-back illegal jumps; counter starts at 2.
    for (int i = 0; i < 300; i++) begin
      apply((i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b1);
      if (i == 251) chk("sat_254", 32'(err_cnt), 32'd254);
      if (i == 252) chk("sat_255", 32'(err_cnt), 32'd255);
    end
    chk("sat_final", 32'(err_cnt), 32'd255);
    chk("sat_err", 32'(step_err), 32'd1);
    chk("sat_fault", 32'(fault), 32'd1);

    // Legal walk 2 -> 9 (0011 -> ... -> 1101).
    for (int i = 3; i < 10; i++) begin
      apply(gray_tab[i], 1'b1);
    end
    chk("pre_rst_bin", 32'(bin_out), 32'd9);
    chk("pre_rst_fault", 32'(fault), 32'd0);

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    #2 set = 1'b0;
    #1;
    chk_reset_state("arst");
    #3 set = 1'b1;

    // First sample after reset: IDLE rule, no step check against 0.
    apply(4'b1111, 1'b1);
    chk("post_bin", 32'(bin_out), 32'd10);
    chk("post_err", 32'(step_err), 32'd0);
    chk("post_valid", 32'(valid), 32'd1);
    chk("post_wrap", 32'(wrap), 32'd0);
    // Next step is legal relative to the loaded sample.
    apply(4'b1110, 1'b1);
    chk("post2_bin", 32'(bin_out), 32'd11);
    chk("post2_err", 32'(step_err), 32'd0);
    chk("post2_dir", 32'(dir_up), 32'd1);
    apply(4'b1110, 1'b0);
    chk("post3_valid", 32'(valid), 32'd0);
    chk("post3_bin", 32'(bin_out), 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
